multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencing FSM for the 64-bit RISC-V core. It drives the instruction decoder, register file, ALU and the two memory ports through fetch, decode, execute, memory and writeback phases, one phase per state. Memory access uses a request/acknowledge handshake with variable latency. It replaces the single-cycle control path when instruction and data memories are not single-cycle.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles a memory request may wait for its ack (used only with MEM_TIMEOUT_EN).
- RETIRE_W, 32: width of the retired-instruction counter.

Ports (clock and reset first):
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  permits leaving IDLE; sampled only in IDLE.
- opcode  in  7  instruction bits [6:0], taken from the instruction register.
- branch_taken  in  1  ALU compare result; valid in EXEC.
- imem_ack  in  1  instruction memory data valid.
- dmem_ack  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- ir_load  out  1  loads the instruction register.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (store).
- reg_write_en  out  1  register file write strobe.
- pc_en  out  1  PC update strobe.
- pc_sel_branch  out  1  selects branch target for the PC update.
- trap  out  1  sticky illegal-opcode or timeout indication.
- retired  out  RETIRE_W  count of completed instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. State is encoded in a 3-bit register.
- Opcode classes:
  - R = 0110011
  - I = 0010011
  - LOAD = 0000011
  - STORE = 0100011
  - BRANCH = 1100011
  - Any other opcode is illegal.
- IDLE: when run=1, go to FETCH; otherwise stay.
- FETCH: imem_req=1. On imem_ack, ir_load=1 in the same cycle and go to DECODE. Otherwise stay.
- DECODE: illegal opcode goes to TRAP; otherwise go to EXEC.
- EXEC, by class:
  - R or I: go to WB.
  - LOAD or STORE: go to MEM.
  - BRANCH: pc_en=1, pc_sel_branch=branch_taken, go to FETCH.
- MEM: dmem_req=1; dmem_we=1 for STORE only. On dmem_ack:
  - LOAD: go to WB.
  - STORE: pc_en=1, go to FETCH.
- WB: reg_write_en=1, pc_en=1, go to FETCH.
- TRAP: trap=1, all strobes 0. Held until rst.
- The instruction class is latched in DECODE and used in EXEC and MEM. The opcode input is not re-sampled after DECODE.
- retired increments by 1 on every cycle with pc_en=1 and wraps modulo 2^RETIRE_W.
- run is ignored outside IDLE. Deasserting run does not stop the core mid-instruction.

## Timing
- Reset values:
  - state = IDLE, retired = 0.
  - All outputs are 0 during and after reset.
- Output classes:
  - Strobe outputs (imem_req, ir_load, dmem_req, dmem_we, reg_write_en, pc_en, pc_sel_branch) are combinational decodes of the state register and the ack inputs. They are not registered.
  - trap and retired are registered.
- Latency with zero-wait memory (ack in the first request cycle):
  - R and I: 4 cycles (FETCH, DECODE, EXEC, WB).
  - BRANCH: 3 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
- Each ack wait cycle adds 1 cycle. imem_req and dmem_req stay high continuously until the ack arrives.
- An ack arriving when its request is low is ignored.
- rst asserted mid-operation: state returns to IDLE immediately and all strobes drop in the same cycle. A pending memory request is abandoned.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A wait counter clears on entry to FETCH or MEM and counts cycles with req=1 and ack=0.
  - When the counter reaches TIMEOUT_CYCLES, the FSM goes to TRAP.
  - An ack in the same cycle as the limit wins: the transition proceeds normally.
- MEM_TIMEOUT_EN undefined: no counter; the FSM waits indefinitely for ack.

## Structure
- Shared package holds:
  - state enum
  - opcode constants (R, I, LOAD, STORE, BRANCH)
  - instruction class typedef
- No sub-module: FSM, class latch, retire counter and optional timeout counter live in one module.

## Test plan
- Reset, run=1, R-type 0x00B50533, acks immediate -> imem_req at cycle 1; reg_write_en and pc_en together in cycle 4; retired=1.
- LOAD 0x0000B503 with dmem_ack delayed 3 cycles -> dmem_req high 4 consecutive cycles, dmem_we=0, reg_write_en one cycle after ack; total 8 cycles.
- STORE 0x00A5B023 -> dmem_we=1 with dmem_req; no reg_write_en; pc_en on the ack cycle.
- BRANCH with branch_taken=1, then again with 0 -> pc_sel_branch 1 then 0, each with pc_en in EXEC; retired += 2.
- Opcode 0x7F -> TRAP after DECODE; trap=1; strobes stay 0 for 20 cycles, including while imem_ack toggles; rst clears.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no imem_ack -> TRAP after 4 wait cycles; rst asserted during MEM in a second run -> IDLE, dmem_req=0 immediately.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// ============================================================================
// Module      : multicycle_ctrl_pkg
// Description : Shared state encoding, opcode constants and instruction-class
//               decode for the multi-cycle RISC-V sequencing FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_R       = 3'd1,
        CLS_I       = 3'd2,
        CLS_LOAD    = 3'd3,
        CLS_STORE   = 3'd4,
        CLS_BRANCH  = 3'd5
    } instr_class_t;

    function automatic instr_class_t decode_class(input logic [6:0] op);
        instr_class_t cls;
        case (op)
            c_op_r:      cls = CLS_R;
            c_op_i:      cls = CLS_I;
            c_op_load:   cls = CLS_LOAD;
            c_op_store:  cls = CLS_STORE;
            c_op_branch: cls = CLS_BRANCH;
            default:     cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle fetch/decode/exec/mem/wb sequencer with req/ack
//               memory handshakes. Optional macro MEM_TIMEOUT_EN adds a
//               memory-wait timeout that diverts to TRAP.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int RETIRE_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [6:0]          opcode,
    input  logic                branch_taken,
    input  logic                imem_ack,
    input  logic                dmem_ack,
    output logic                imem_req,
    output logic                ir_load,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic                reg_write_en,
    output logic                pc_en,
    output logic                pc_sel_branch,
    output logic                trap,
    output logic [RETIRE_W-1:0] retired
);

    state_t                r_state;
    state_t                w_next_state;
    instr_class_t          r_cls;
    logic                  r_trap;
    logic [RETIRE_W-1:0]   r_retired;
    logic                  w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (run) w_next_state = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack)       w_next_state = S_DECODE;
                else if (w_timeout) w_next_state = S_TRAP;
            end
            S_DECODE: begin
                if (decode_class(opcode) == CLS_ILLEGAL) w_next_state = S_TRAP;
                else                                     w_next_state = S_EXEC;
            end
            S_EXEC: begin
                case (r_cls)
                    CLS_R, CLS_I:         w_next_state = S_WB;
                    CLS_LOAD, CLS_STORE:  w_next_state = S_MEM;
                    default:              w_next_state = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (dmem_ack)       w_next_state = (r_cls == CLS_LOAD) ? S_WB : S_FETCH;
                else if (w_timeout) w_next_state = S_TRAP;
            end
            S_WB:    w_next_state = S_FETCH;
            S_TRAP:  w_next_state = S_TRAP;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Strobes are pure decodes of state and acks so they drop as soon as rst hits.
    always_comb begin
        imem_req      = 1'b0;
        ir_load       = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        reg_write_en  = 1'b0;
        pc_en         = 1'b0;
        pc_sel_branch = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ack;
            end
            S_EXEC: begin
                if (r_cls == CLS_BRANCH) begin
                    pc_en         = 1'b1;
                    pc_sel_branch = branch_taken;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (r_cls == CLS_STORE);
                pc_en    = (r_cls == CLS_STORE) && dmem_ack;
            end
            S_WB: begin
                reg_write_en = 1'b1;
                pc_en        = 1'b1;
            end
            default: ;
        endcase
    end

    // Class is captured once in DECODE; opcode may change afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cls <= CLS_ILLEGAL;
        end else if (r_state == S_DECODE) begin
            r_cls <= decode_class(opcode);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trap    <= 1'b0;
            r_retired <= '0;
        end else begin
            r_trap <= (w_next_state == S_TRAP);
            if (pc_en) begin
                r_retired <= r_retired + {{(RETIRE_W-1){1'b0}}, 1'b1};
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int c_wait_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_wait_w-1:0] r_wait_cnt;
    logic                w_waiting;

    assign w_waiting = (imem_req && !imem_ack) || (dmem_req && !dmem_ack);
    // Limit is hit on the last permitted wait cycle; an ack there takes priority.
    assign w_timeout = w_waiting && (r_wait_cnt == c_wait_w'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (w_next_state != r_state) begin
            r_wait_cnt <= '0;
        end else if (w_waiting) begin
            r_wait_cnt <= r_wait_cnt + {{(c_wait_w-1){1'b0}}, 1'b1};
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign trap    = r_trap;
    assign retired = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Scoreboard bench for multicycle_ctrl; per-cycle expected
//               strobe/trap vectors are queued as stimulus is applied.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        imem_ack;
    logic        dmem_ack;
    logic        imem_req, ir_load, dmem_req, dmem_we;
    logic        reg_write_en, pc_en, pc_sel_branch, trap;
    logic [31:0] retired;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  obs_q[$];
    logic [31:0] exp_retired = 0;

    // {imem_req, ir_load, dmem_req, dmem_we, reg_write_en, pc_en, pc_sel_branch, trap}
    localparam logic [7:0] V_ZERO = 8'b0000_0000;
    localparam logic [7:0] V_FW   = 8'b1000_0000;
    localparam logic [7:0] V_FA   = 8'b1100_0000;
    localparam logic [7:0] V_BRT  = 8'b0000_0110;
    localparam logic [7:0] V_BRN  = 8'b0000_0100;
    localparam logic [7:0] V_LW   = 8'b0010_0000;
    localparam logic [7:0] V_SW   = 8'b0011_0000;
    localparam logic [7:0] V_SA   = 8'b0011_0100;
    localparam logic [7:0] V_WB   = 8'b0000_1100;
    localparam logic [7:0] V_TRAP = 8'b0000_0001;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .TIMEOUT_CYCLES (4),
        .RETIRE_W       (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .opcode        (opcode),
        .branch_taken  (branch_taken),
        .imem_ack      (imem_ack),
        .dmem_ack      (dmem_ack),
        .imem_req      (imem_req),
        .ir_load       (ir_load),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .reg_write_en  (reg_write_en),
        .pc_en         (pc_en),
        .pc_sel_branch (pc_sel_branch),
        .trap          (trap),
        .retired       (retired)
    );

    // One clock of stimulus: queue the expected vector, capture the observed one.
    task automatic cycle(input logic ia, input logic da, input logic bt, input logic [7:0] exp);
        imem_ack     = ia;
        dmem_ack     = da;
        branch_taken = bt;
        exp_q.push_back(exp);
        @(negedge clk);
        obs_q.push_back({imem_req, ir_load, dmem_req, dmem_we,
                         reg_write_en, pc_en, pc_sel_branch, trap});
        @(posedge clk);
        #1;
    endtask

    // Issues one instruction starting in FETCH with iw fetch waits and dw data waits.
    task automatic run_instr(input logic [6:0] op, input int iw, input int dw, input logic bt);
        logic is_br, is_ld, is_st;
        is_br  = (op == 7'b1100011);
        is_ld  = (op == 7'b0000011);
        is_st  = (op == 7'b0100011);
        opcode = op;
        repeat (iw) cycle(1'b0, 1'b0, 1'b0, V_FW);
        cycle(1'b1, 1'b0, 1'b0, V_FA);
        cycle(1'b1, 1'b1, 1'b0, V_ZERO);
        opcode = 7'h7F;
        if (is_br) begin
            cycle(1'b0, 1'b0, bt, bt ? V_BRT : V_BRN);
        end else begin
            cycle(1'b0, 1'b0, 1'b1, V_ZERO);
            if (is_ld || is_st) begin
                repeat (dw) cycle(1'b0, 1'b0, 1'b0, is_st ? V_SW : V_LW);
                cycle(1'b0, 1'b1, 1'b0, is_st ? V_SA : V_LW);
            end
            if (!is_st) cycle(1'b0, 1'b0, 1'b1, V_WB);
        end
        exp_retired = exp_retired + 1;
    endtask

    task automatic test_reset();
        logic [7:0] e, o;
        int idx = 0;
        rst = 1'b1; run = 1'b1; opcode = 7'h33;
        repeat (3) cycle(1'b1, 1'b1, 1'b1, V_ZERO);
        rst = 1'b0; run = 1'b0;
        repeat (2) cycle(1'b1, 1'b1, 1'b0, V_ZERO);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset[%0d]: observed %b expected %b", idx, o, e);
            end
            idx++;
        end
        vectors++;
        if (retired !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_retired: observed %0d expected 0", retired);
        end
    endtask

    task automatic test_r_type();
        logic [7:0] e, o;
        int idx = 0;
        run = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, V_ZERO);
        run = 1'b0;
        run_instr(7'h33, 0, 0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL r_type[%0d]: observed %b expected %b", idx, o, e);
            end
            idx++;
        end
        vectors++;
        if (retired !== exp_retired) begin
            miscompares++;
            $display("FAIL r_type_retired: observed %0d expected %0d", retired, exp_retired);
        end
    endtask

    task automatic test_mem();
        logic [7:0] e, o;
        int idx = 0;
        run_instr(7'h03, 0, 3, 1'b0);
        run_instr(7'h23, 1, 2, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL load_store[%0d]: observed %b expected %b", idx, o, e);
            end
            idx++;
        end
        vectors++;
        if (retired !== exp_retired) begin
            miscompares++;
            $display("FAIL load_store_retired: observed %0d expected %0d", retired, exp_retired);
        end
    endtask

    task automatic test_branch();
        logic [7:0] e, o;
        int idx = 0;
        run_instr(7'h63, 0, 0, 1'b1);
        run_instr(7'h63, 0, 0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL branch[%0d]: observed %b expected %b", idx, o, e);
            end
            idx++;
        end
        vectors++;
        if (retired !== exp_retired) begin
            miscompares++;
            $display("FAIL branch_retired: observed %0d expected %0d", retired, exp_retired);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e, o;
        int idx = 0;
`ifdef MEM_TIMEOUT_EN
        run_instr(7'h13, 3, 0, 1'b0);
`else
        run_instr(7'h13, 12, 0, 1'b0);
`endif
        run_instr(7'h33, 0, 0, 1'b0);
        run_instr(7'h23, 0, 0, 1'b0);
        run_instr(7'h03, 0, 0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: observed %b expected %b", idx, o, e);
            end
            idx++;
        end
        vectors++;
        if (retired !== exp_retired) begin
            miscompares++;
            $display("FAIL back_to_back_retired: observed %0d expected %0d", retired, exp_retired);
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [7:0] e, o;
        int idx = 0;
        opcode = 7'h03;
        cycle(1'b1, 1'b0, 1'b0, V_FA);
        cycle(1'b0, 1'b0, 1'b0, V_ZERO);
        cycle(1'b0, 1'b0, 1'b0, V_ZERO);
        cycle(1'b0, 1'b0, 1'b0, V_LW);
        vectors++;
        if (dmem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_mem_req_before_rst: observed %b expected 1", dmem_req);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({imem_req, ir_load, dmem_req, dmem_we, reg_write_en, pc_en, pc_sel_branch, trap} !== V_ZERO) begin
            miscompares++;
            $display("FAIL mid_mem_strobes_at_rst: observed %b expected %b",
                     {imem_req, ir_load, dmem_req, dmem_we, reg_write_en, pc_en, pc_sel_branch, trap}, V_ZERO);
        end
        vectors++;
        if (retired !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_mem_retired_at_rst: observed %0d expected 0", retired);
        end
        exp_retired = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(1'b0, 1'b1, 1'b0, V_ZERO);
        run = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, V_ZERO);
        run = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL mid_mem[%0d]: observed %b expected %b", idx, o, e);
            end
            idx++;
        end
    endtask

    task automatic test_trap();
        logic [7:0] e, o;
        int idx = 0;
        opcode = 7'h7F;
        cycle(1'b1, 1'b0, 1'b0, V_FA);
        cycle(1'b0, 1'b0, 1'b0, V_ZERO);
        for (int i = 0; i < 20; i++) begin
            run    = i[2];
            opcode = (i[0]) ? 7'h33 : 7'h03;
            cycle(i[0], ~i[0], i[1], V_TRAP);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL trap[%0d]: observed %b expected %b", idx, o, e);
            end
            idx++;
        end
        vectors++;
        if (retired !== exp_retired) begin
            miscompares++;
            $display("FAIL trap_retired: observed %0d expected %0d", retired, exp_retired);
        end
        rst = 1'b1; run = 1'b0;
        #1;
        vectors++;
        if (trap !== 1'b0 || retired !== 32'd0) begin
            miscompares++;
            $display("FAIL trap_cleared_by_rst: observed trap=%b retired=%0d expected trap=0 retired=0",
                     trap, retired);
        end
        exp_retired = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] e, o;
        int idx = 0;
        run = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, V_ZERO);
        run = 1'b0;
        repeat (4) cycle(1'b0, 1'b0, 1'b0, V_FW);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, V_TRAP);
        cycle(1'b1, 1'b1, 1'b0, V_TRAP);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL timeout[%0d]: observed %b expected %b", idx, o, e);
            end
            idx++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask
`endif

    initial begin
        imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0;
        test_reset();
        test_r_type();
        test_mem();
        test_branch();
        test_back_to_back();
        test_reset_mid_mem();
        test_trap();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
